irq_ctrl_6502: RTL

Eight-source interrupt priority controller for the 6502 SoC. It sits on the CPU peripheral bus beside the UART, GPIO and CIA-style blocks, and collects their interrupt requests (UART, timer/CNT, serial port, FLAG, GPIO). It applies per-source edge/level mode and masking, and drives the CPU's low-true IRQ line. A vector register lets the ISR identify the highest-priority source in one read and acknowledge it.

---
 rtl/irq_pkg.sv | 22 ++
 rtl/irq_prio_enc.sv | 27 ++
 rtl/irq_ctrl_6502.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/irq_pkg.sv
// Shared definitions for the 6502 SoC interrupt priority controller.
package irq_pkg;

  // Register map.
  localparam logic [1:0] REG_PEND = 2'd0;
  localparam logic [1:0] REG_MASK = 2'd1;
  localparam logic [1:0] REG_MODE = 2'd2;
  localparam logic [1:0] REG_VEC  = 2'd3;

  // IRQ line state machine.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACTIVE  = 2'd1,
    HOLDOFF = 2'd2
  } irq_state_e;

  // Convert a 3-bit source index to its one-hot pending mask.
  function automatic logic [7:0] onehot8(input logic [2:0] idx);
    return 8'b0000_0001 << idx;
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-first 8->3 priority encoder; bit 0 has the highest priority.
module irq_prio_enc
  import irq_pkg::*;
(
  input  logic [7:0] req,
  output logic       any,
  output logic [2:0] idx
);

  // Pick the lowest-numbered asserted request; index is 0 when nothing is set.
  always_comb begin
    any = |req;
    idx = 3'd0;
    casez (req)
      8'b???????1: idx = 3'd0;
      8'b??????10: idx = 3'd1;
      8'b?????100: idx = 3'd2;
      8'b????1000: idx = 3'd3;
      8'b???10000: idx = 3'd4;
      8'b??100000: idx = 3'd5;
      8'b?1000000: idx = 3'd6;
      8'b10000000: idx = 3'd7;
      default:     idx = 3'd0;
    endcase
  end

endmodule

// File: rtl/irq_ctrl_6502.sv
// Eight-source interrupt controller: edge/level pending, masking, vector
// read with acknowledge, and a low-true IRQ line with a hold-off pulse.
module irq_ctrl_6502
  import irq_pkg::*;
#(
  parameter int NSRC = 8
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [NSRC-1:0] src,
  input  logic            cs,
  input  logic            we,
  input  logic [1:0]      addr,
  input  logic [7:0]      din,
  output logic [7:0]      dout,
  output logic            irq_n
);

  logic [NSRC-1:0] src_q_r;
  logic [7:0]      pend_r;
  logic [7:0]      mask_r;
  logic [7:0]      mode_r;
  logic [7:0]      dout_r;
  logic            irq_n_r;
  irq_state_e      state_r;
  irq_state_e      state_nxt_s;

  logic [7:0]      active_s;
  logic            any_s;
  logic [2:0]      idx_s;
  logic            rd_s;
  logic            wr_s;
  logic            ack_s;
  logic [7:0]      w1c_s;
  logic [7:0]      ack_mask_s;
  logic [7:0]      clr_s;
  logic [7:0]      rise_s;
  logic [7:0]      pend_nxt_s;
  logic [7:0]      rdata_s;

  assign active_s = pend_r & mask_r;

  irq_prio_enc u_prio_enc (
    .req (active_s),
    .any (any_s),
    .idx (idx_s)
  );

  // Bus decode, acknowledge and the next pending vector (set beats clear).
  always_comb begin
    rd_s       = cs & ~we;
    wr_s       = cs & we;
    ack_s      = rd_s & (addr == REG_VEC) & any_s;
    rise_s     = src & ~src_q_r;
    w1c_s      = 8'h00;
    ack_mask_s = 8'h00;
    if (wr_s && (addr == REG_PEND)) begin
      w1c_s = din;
    end else begin
      w1c_s = 8'h00;
    end
    if (ack_s) begin
      ack_mask_s = onehot8(idx_s);
    end else begin
      ack_mask_s = 8'h00;
    end
    // Clears only ever touch edge-mode bits; level bits track src directly.
    clr_s      = (w1c_s | ack_mask_s) & mode_r;
    pend_nxt_s = (mode_r & (rise_s | (pend_r & ~clr_s))) | (~mode_r & src);
  end

  // Read data mux, sampled into dout on a read strobe.
  always_comb begin
    rdata_s = 8'h00;
    case (addr)
      REG_PEND: rdata_s = pend_r;
      REG_MASK: rdata_s = mask_r;
      REG_MODE: rdata_s = mode_r;
      REG_VEC:  rdata_s = {any_s, 4'b0000, idx_s};
      default:  rdata_s = 8'h00;
    endcase
  end

  // IRQ state machine next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (any_s) begin
          state_nxt_s = ACTIVE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ACTIVE: begin
        if (ack_s) begin
          state_nxt_s = HOLDOFF;
        end else if (!any_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = ACTIVE;
        end
      end
      HOLDOFF: begin
        if (any_s) begin
          state_nxt_s = ACTIVE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Pending, configuration registers and source history.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      src_q_r <= src;
      pend_r  <= 8'h00;
      mask_r  <= 8'h00;
      mode_r  <= 8'h00;
    end else begin
      src_q_r <= src;
      pend_r  <= pend_nxt_s;
      if (wr_s && (addr == REG_MASK)) begin
        mask_r <= din;
      end else begin
        mask_r <= mask_r;
      end
      if (wr_s && (addr == REG_MODE)) begin
        mode_r <= din;
      end else begin
        mode_r <= mode_r;
      end
    end
  end

  // Read data register: loaded on reads, held otherwise (writes leave it).
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      dout_r <= 8'h00;
    end else if (rd_s) begin
      dout_r <= rdata_s;
    end else begin
      dout_r <= dout_r;
    end
  end

  // State register and registered low-true IRQ output.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r <= IDLE;
      irq_n_r <= 1'b1;
    end else begin
      state_r <= state_nxt_s;
      irq_n_r <= (state_nxt_s != ACTIVE);
    end
  end

  assign dout  = dout_r;
  assign irq_n = irq_n_r;

endmodule
